// File: rtl/fpu_adder_pkg.sv
// Shared types, default widths and the leading-one window extractor for the FP adder datapath.
package fpu_adder_pkg;

  typedef enum logic {
    DBL = 1'b0,
    SGL = 1'b1
  } fp_mode_e;

  localparam int unsigned FPA_SUM_W   = 59;
  localparam int unsigned FPA_OUT_W   = 56;
  localparam int unsigned FPA_EXP_W   = 11;
  localparam int unsigned FPA_SGL_MSB = 26;
  localparam int unsigned FPA_CNT_W   = 16;
  localparam int unsigned LZA_MAX_W   = 128;

  // Result is right-justified: bit out_w-1 holds sum[top], bits below top's LSB fill with zero.
  function automatic logic [LZA_MAX_W-1:0] lza_window(input logic [LZA_MAX_W-1:0] sum,
                                                      input int unsigned          top,
                                                      input int unsigned          out_w);
    logic [LZA_MAX_W-1:0] aligned;
    aligned = sum << (LZA_MAX_W - 1 - top);
    return aligned >> (LZA_MAX_W - out_w);
  endfunction

endpackage

// File: rtl/lza_pipe_slice.sv
// Single valid/ready register slice with synchronous flush; accepts when empty or when draining.
module lza_pipe_slice #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (in_ready) begin
        valid_q <= in_valid;
      end
      if (in_valid && in_ready && !flush) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/lza_norm_correct_pipe.sv
// LZA post-normalisation correction: checks the expected leading one, selects the aligned or
// 1-bit-left mantissa window and adjusts the exponent, over a 2-stage elastic pipeline.
module lza_norm_correct_pipe
  import fpu_adder_pkg::*;
#(
  parameter int unsigned SUM_W   = FPA_SUM_W,
  parameter int unsigned OUT_W   = FPA_OUT_W,
  parameter int unsigned EXP_W   = FPA_EXP_W,
  parameter int unsigned SGL_MSB = FPA_SGL_MSB,
  parameter int unsigned CNT_W   = FPA_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode_sgl,
  input  logic [SUM_W-1:0] sum_shifted,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] correct_sum,
  output logic [EXP_W-1:0] exp_out,
  output logic             second_shift,
  output logic             zero_flag,
  output logic             uflow_flag,
  output logic [CNT_W-1:0] corr_count
);

  localparam int unsigned S1_W = SUM_W + EXP_W + 2;
  localparam int unsigned S2_W = OUT_W + EXP_W + 3;

  logic [S1_W-1:0] s1_d, s1_q;
  logic [S2_W-1:0] s2_d, s2_q;
  logic            s1_valid, s2_in_ready;

  // Stage 1: capture the beat together with its leading-one check
  logic in_hit;
  always_comb begin
    in_hit = (fp_mode_e'(mode_sgl) == SGL) ? sum_shifted[SGL_MSB] : sum_shifted[SUM_W-1];
    s1_d   = {mode_sgl, in_hit, exp_in, sum_shifted};
  end

  lza_pipe_slice #(.DATA_W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  logic [SUM_W-1:0] s1_sum;
  logic [EXP_W-1:0] s1_exp;
  logic             s1_hit;
  fp_mode_e         s1_mode;
  int unsigned      top_chk, top_sel;
  logic [OUT_W-1:0] win;
  logic [EXP_W-1:0] exp_c;
  logic             ss_c, zf_c, uf_c;

  // Stage 2 input: window select, exponent correction and flags
  always_comb begin
    s1_sum  = s1_q[SUM_W-1:0];
    s1_exp  = s1_q[SUM_W +: EXP_W];
    s1_hit  = s1_q[SUM_W+EXP_W];
    s1_mode = fp_mode_e'(s1_q[SUM_W+EXP_W+1]);
    top_chk = (s1_mode == SGL) ? SGL_MSB : SUM_W - 1;
    top_sel = top_chk;
    exp_c   = s1_exp;
    ss_c    = 1'b0;
    zf_c    = 1'b0;
    uf_c    = 1'b0;
    if (s1_sum == '0) begin
      zf_c  = 1'b1;
      exp_c = '0;
    end else if (!s1_hit) begin
      if (s1_exp != '0) begin
        top_sel = top_chk - 1;
        ss_c    = 1'b1;
        exp_c   = s1_exp - EXP_W'(1);
      end else begin
        uf_c  = 1'b1;
        exp_c = '0;
      end
    end
    win = zf_c ? '0 : OUT_W'(lza_window(LZA_MAX_W'(s1_sum), top_sel, OUT_W));
    s2_d = {win, exp_c, ss_c, zf_c, uf_c};
  end

  lza_pipe_slice #(.DATA_W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign correct_sum  = s2_q[S2_W-1 -: OUT_W];
  assign exp_out      = s2_q[3 +: EXP_W];
  assign second_shift = s2_q[2];
  assign zero_flag    = s2_q[1];
  assign uflow_flag   = s2_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_count <= '0;
    end else if (!flush && out_valid && out_ready && second_shift && (corr_count != '1)) begin
      corr_count <= corr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lza_norm_correct_pipe.sv
// Scoreboard bench for lza_norm_correct_pipe: bench-side window model, handshake and flag checks.
module tb_lza_norm_correct_pipe;

  typedef struct packed {
    logic [55:0] sum;
    logic [10:0] e;
    logic        ss;
    logic        zf;
    logic        uf;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        mode_sgl;
  logic [58:0] sum_shifted;
  logic [10:0] exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] correct_sum;
  logic [10:0] exp_out;
  logic        second_shift;
  logic        zero_flag;
  logic        uflow_flag;
  logic [15:0] corr_count;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_cnt = 0;
  beat_t sb[$];

  lza_norm_correct_pipe #(.SUM_W(59), .OUT_W(56), .EXP_W(11), .SGL_MSB(26), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode_sgl     (mode_sgl),
    .sum_shifted  (sum_shifted),
    .exp_in       (exp_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .correct_sum  (correct_sum),
    .exp_out      (exp_out),
    .second_shift (second_shift),
    .zero_flag    (zero_flag),
    .uflow_flag   (uflow_flag),
    .corr_count   (corr_count)
  );

  always #5 clk = ~clk;

  function automatic beat_t model(input logic m, input logic [58:0] s, input logic [10:0] e);
    beat_t b;
    int    t, top, idx;
    b = '0;
    t = m ? 26 : 58;
    if (s == '0) begin
      b.zf = 1'b1;
      return b;
    end
    top = t;
    if (s[t]) b.e = e;
    else if (e != 11'd0) begin
      top  = t - 1;
      b.ss = 1'b1;
      b.e  = e - 11'd1;
    end else b.uf = 1'b1;
    for (int i = 0; i < 56; i++) begin
      idx = top - i;
      if (idx >= 0) b.sum[55-i] = s[idx];
    end
    return b;
  endfunction

  // One cycle: drive at negedge, observe after settling, pop on output transfer, push on accept.
  task automatic tick(input logic v, input logic m, input logic [58:0] s, input logic [10:0] e,
                      input logic ordy, output logic took, output logic under,
                      output beat_t got, output beat_t want, output int infl, output logic ir);
    @(negedge clk);
    in_valid = v; mode_sgl = m; sum_shifted = s; exp_in = e; out_ready = ordy;
    #1;
    infl  = sb.size();
    ir    = in_ready;
    took  = out_valid && out_ready;
    got   = {correct_sum, exp_out, second_shift, zero_flag, uflow_flag};
    want  = '0;
    under = 1'b0;
    if (took) begin
      if (sb.size() == 0) under = 1'b1;
      else begin
        want = sb.pop_front();
        if (want.ss) exp_cnt++;
      end
    end
    if (v && in_ready) sb.push_back(model(m, s, e));
  endtask

  task automatic test_reset();
    beat_t got;
    flush = 0; in_valid = 0; mode_sgl = 0; sum_shifted = '0; exp_in = '0; out_ready = 0;
    rst_n = 0;
    #3;
    got = {correct_sum, exp_out, second_shift, zero_flag, uflow_flag};
    n_cmp++;
    if (got !== '0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: got %h valid %b want 0", got, out_valid);
    end
    n_cmp++;
    if (corr_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_count: got %0d want 0", corr_count);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [58:0] vs[10];
    logic        vm[10];
    logic [10:0] ve[10];
    logic        took, under, ir, done;
    beat_t       got, want;
    int          infl, lat;
    vs = '{59'h400_0000_0000_0000, 59'h5A5_A5A5_A5A5_A5A5, 59'h2F0_0F0F_1234_567B,
           59'h000_0000_0200_0000, 59'h7FF_0000_0612_3457, 59'h0, 59'h0,
           59'h1FF_FFFF_FFFF_FFFF, 59'h000_0000_0000_0001, 59'h000_0000_0000_0003};
    vm = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1};
    ve = '{11'h400, 11'h400, 11'h400, 11'h080, 11'h080, 11'h3A5, 11'h000, 11'h000, 11'h001, 11'h000};
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, vm[k], vs[k], ve[k], 1'b1, took, under, got, want, infl, ir);
      lat = 0; done = 0;
      for (int c = 0; c < 8 && !done; c++) begin
        tick(1'b0, 1'b0, '0, '0, 1'b1, took, under, got, want, infl, ir);
        lat++;
        if (took) begin
          done = 1;
          n_cmp++;
          if (under || got !== want) begin
            n_bad++; $display("FAIL directed_%0d: got %h want %h", k, got, want);
          end
        end
      end
      n_cmp++;
      if (!done || lat != 2) begin
        n_bad++; $display("FAIL latency_%0d: got %0d want 2 (done=%b)", k, lat, done);
      end
    end
    tick(1'b0, 1'b0, '0, '0, 1'b1, took, under, got, want, infl, ir);
    n_cmp++;
    if (corr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL directed_count: got %0d want %0d", corr_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic        took, under, ir, ordy, v;
    beat_t       got, want;
    int          infl, sent, rcvd;
    logic [58:0] s;
    sent = 0; rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 6; c++) begin
      ordy = !(c >= 3 && c < 6);
      v = (sent < 6);
      s = {1'b0, 58'(64'h0123_4567_89AB_CDEF * (sent + 3))} | (59'(sent[0]) << 58);
      tick(v, 1'b0, s, 11'h200 + 11'(sent), ordy, took, under, got, want, infl, ir);
      if (v && ir) sent++;
      n_cmp++;
      if (ir !== ((infl < 2) || ordy)) begin
        n_bad++; $display("FAIL b2b_in_ready_c%0d: got %b want %b", c, ir, (infl < 2) || ordy);
      end
      if (took) begin
        rcvd++;
        n_cmp++;
        if (under || got !== want) begin
          n_bad++; $display("FAIL b2b_beat_%0d: got %h want %h", rcvd, got, want);
        end
      end
    end
    tick(1'b0, 1'b0, '0, '0, 1'b1, took, under, got, want, infl, ir);
    n_cmp++;
    if (rcvd != 6 || took || sb.size() != 0) begin
      n_bad++; $display("FAIL b2b_total: got %0d extra %b left %0d want 6", rcvd, took, sb.size());
    end
    n_cmp++;
    if (corr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL b2b_count: got %0d want %0d", corr_count, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic        took, under, ir, ordy, v, m;
    beat_t       got, want;
    int          infl;
    logic [58:0] s;
    logic [10:0] e;
    for (int c = 0; c < 200; c++) begin
      v    = ($urandom_range(0, 3) != 0);
      m    = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      s    = 59'({$urandom, $urandom});
      case ($urandom_range(0, 4))
        0:       s = '0;
        1, 2:    s = s >> $urandom_range(1, 40);
        default: ;
      endcase
      e = ($urandom_range(0, 4) == 0) ? 11'd0 : 11'($urandom);
      tick(v, m, s, e, ordy, took, under, got, want, infl, ir);
      n_cmp++;
      if (ir !== ((infl < 2) || ordy)) begin
        n_bad++; $display("FAIL rnd_in_ready_c%0d: got %b want %b", c, ir, (infl < 2) || ordy);
      end
      if (took) begin
        n_cmp++;
        if (under || got !== want) begin
          n_bad++; $display("FAIL rnd_beat_c%0d: got %h want %h", c, got, want);
        end
      end
    end
    for (int c = 0; c < 6; c++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b1, took, under, got, want, infl, ir);
      if (took) begin
        n_cmp++;
        if (under || got !== want) begin
          n_bad++; $display("FAIL rnd_drain_c%0d: got %h want %h", c, got, want);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0 || corr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL rnd_final: left %0d count %0d want 0 / %0d", sb.size(), corr_count, exp_cnt);
    end
  endtask

  task automatic test_flush();
    logic  took, under, ir;
    beat_t got, want;
    int    infl, extra;
    tick(1'b1, 1'b0, 59'h100_0000_0000_00F1, 11'h123, 1'b0, took, under, got, want, infl, ir);
    tick(1'b1, 1'b0, 59'h0FF_0000_0000_00F2, 11'h124, 1'b0, took, under, got, want, infl, ir);
    @(negedge clk);
    in_valid = 0; flush = 1;
    @(negedge clk);
    flush = 0; out_ready = 1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if (corr_count !== 16'(exp_cnt)) begin
      n_bad++; $display("FAIL flush_count: got %0d want %0d", corr_count, exp_cnt);
    end
    sb.delete();
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b1, took, under, got, want, infl, ir);
      if (took) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++; $display("FAIL flush_leftover: got %0d beats want 0", extra);
    end
  endtask

  task automatic test_reset_midstream();
    logic  took, under, ir;
    beat_t got, want;
    int    infl;
    for (int k = 0; k < 3; k++)
      tick(1'b1, 1'b0, 59'h0C0_0000_0000_0011 + 59'(k), 11'h300, 1'b0, took, under, got, want, infl, ir);
    #2 rst_n = 0;
    #1;
    got = {correct_sum, exp_out, second_shift, zero_flag, uflow_flag};
    n_cmp++;
    if (got !== '0 || out_valid !== 1'b0 || corr_count !== 16'd0) begin
      n_bad++; $display("FAIL midreset: got %h valid %b count %0d want 0", got, out_valid, corr_count);
    end
    sb.delete();
    exp_cnt = 0;
    in_valid = 0;
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0, '0, '0, 1'b1, took, under, got, want, infl, ir);
      n_cmp++;
      if (took || ir !== 1'b1) begin
        n_bad++; $display("FAIL midreset_after_c%0d: got valid %b ready %b want 0/1", c, took, ir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
